// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: the word type, the fetch
// increment and the NOP that fills a flushed pipeline slot.
package arm_pkg;

   typedef logic [31:0] word_t;

   localparam word_t NOP_INST   = 32'd0;
   localparam word_t WORD_BYTES = 32'd4;
   localparam word_t ALIGN_MASK = ~32'h3;

   function automatic word_t align_word(input word_t addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with the next-PC selection: reset, branch redirect,
// freeze hold and sequential increment. The PC is always word aligned.
module pc_reg
   import arm_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   word_t pc_q;
   word_t pc_d;
   word_t pc_inc;

   // Increment wraps modulo 2^32, so 0xFFFFFFFC advances to 0.
   assign pc_inc = pc_q + WORD_BYTES;

   always_comb begin
      pc_d = pc_q;
      if (branch_taken) begin
         pc_d = align_word(branch_addr);
      end else if (!freeze) begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= align_word(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc       = pc_q;
   assign pc_plus4 = pc_inc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register with freeze and branch flush,
// and saturating fetch/stall/flush event counters.
module fetch_stage
   import arm_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             branch_taken,
   input  logic [31:0]      branch_addr,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_inst,
   output logic [31:0]      inst_out,
   output logic [31:0]      pc_out,
   output logic             valid_out,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   word_t pc;
   word_t pc_plus4;
   logic  advance;
   logic  stall;

   // A branch overrides a simultaneous freeze, so that cycle is not a stall.
   assign advance = !branch_taken && !freeze;
   assign stall   = !branch_taken && freeze;

   pc_reg #(
      .RESET_PC(RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .rst         (rst),
      .freeze      (freeze),
      .branch_taken(branch_taken),
      .branch_addr (branch_addr),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
   );

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_out  <= NOP_INST;
         pc_out    <= 32'd0;
         valid_out <= 1'b0;
      end else if (branch_taken) begin
         inst_out  <= NOP_INST;
         pc_out    <= 32'd0;
         valid_out <= 1'b0;
      end else if (advance) begin
         inst_out  <= imem_inst;
         pc_out    <= pc_plus4;
         valid_out <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (advance && fetch_cnt != CNT_MAX) begin
            fetch_cnt <= fetch_cnt + CNT_ONE;
         end
         if (stall && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (branch_taken && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, randomized run against a
// cycle-level reference model, and counter saturation on a narrow instance.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        valid_out;
   logic [15:0] fetch_cnt;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   logic        rst4;
   logic [31:0] imem_addr4;
   logic [31:0] imem_inst4;
   logic [31:0] inst_out4;
   logic [31:0] pc_out4;
   logic        valid_out4;
   logic [3:0]  fetch_cnt4;
   logic [3:0]  stall_cnt4;
   logic [3:0]  flush_cnt4;

   logic [31:0] mem [64];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign imem_inst  = mem[imem_addr[7:2]];
   assign imem_inst4 = mem[imem_addr4[7:2]];

   fetch_stage #(.RESET_PC(32'd0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .inst_out(inst_out), .pc_out(pc_out), .valid_out(valid_out),
      .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   fetch_stage #(.RESET_PC(32'd0), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst4), .freeze(1'b0), .branch_taken(1'b0),
      .branch_addr(32'd0), .imem_addr(imem_addr4), .imem_inst(imem_inst4),
      .inst_out(inst_out4), .pc_out(pc_out4), .valid_out(valid_out4),
      .fetch_cnt(fetch_cnt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
   );

   typedef struct {
      logic        r;
      logic        f;
      logic        b;
      logic [31:0] a;
      logic [31:0] e_addr;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [15:0] e_fetch;
      logic [15:0] e_stall;
      logic [15:0] e_flush;
   } vec_t;

   vec_t tbl [13];

   // reference model state
   logic [31:0] m_pc, m_inst, m_pco;
   logic        m_valid;
   logic [15:0] m_fetch, m_stall, m_flush;

   function automatic logic [31:0] w(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   function automatic vec_t mk(input logic r, f, b, input logic [31:0] a,
                               input logic [31:0] ea, ei, ep, input logic ev,
                               input logic [15:0] ef, es, efl);
      vec_t v;
      v.r = r; v.f = f; v.b = b; v.a = a;
      v.e_addr = ea; v.e_inst = ei; v.e_pc = ep; v.e_valid = ev;
      v.e_fetch = ef; v.e_stall = es; v.e_flush = efl;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, f, b, input logic [31:0] a);
      rst = r; freeze = f; branch_taken = b; branch_addr = a;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // One cycle of fetch behaviour described directly from the stage rules.
   task automatic model_edge(input logic r, f, b, input logic [31:0] a);
      if (r) begin
         m_pc = 32'd0; m_inst = 32'd0; m_pco = 32'd0; m_valid = 1'b0;
         m_fetch = 16'd0; m_stall = 16'd0; m_flush = 16'd0;
      end else if (b) begin
         m_pc = {a[31:2], 2'b00};
         m_inst = 32'd0; m_pco = 32'd0; m_valid = 1'b0;
         m_flush = sat16(m_flush);
      end else if (f) begin
         m_stall = sat16(m_stall);
      end else begin
         m_inst  = mem[m_pc[7:2]];
         m_pc    = m_pc + 32'd4;
         m_pco   = m_pc;
         m_valid = 1'b1;
         m_fetch = sat16(m_fetch);
      end
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
      rst4 = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = w(i);

      //             r  f  b  addr           imem_addr      inst    pc_out        v  fetch stall flush
      tbl[0]  = mk(1, 0, 0, 32'h0,        32'h0,         32'h0,  32'h0,        0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 32'h0,        32'h4,         w(0),   32'h4,        1, 1, 0, 0);
      tbl[2]  = mk(0, 0, 0, 32'h0,        32'h8,         w(1),   32'h8,        1, 2, 0, 0);
      tbl[3]  = mk(0, 1, 0, 32'h0,        32'h8,         w(1),   32'h8,        1, 2, 1, 0);
      tbl[4]  = mk(0, 1, 0, 32'h0,        32'h8,         w(1),   32'h8,        1, 2, 2, 0);
      tbl[5]  = mk(0, 0, 0, 32'h0,        32'hC,         w(2),   32'hC,        1, 3, 2, 0);
      tbl[6]  = mk(0, 0, 0, 32'h0,        32'h10,        w(3),   32'h10,       1, 4, 2, 0);
      tbl[7]  = mk(0, 1, 1, 32'h26,       32'h24,        32'h0,  32'h0,        0, 4, 2, 1);
      tbl[8]  = mk(0, 0, 0, 32'h0,        32'h28,        w(9),   32'h28,       1, 5, 2, 1);
      tbl[9]  = mk(1, 1, 1, 32'h10,       32'h0,         32'h0,  32'h0,        0, 0, 0, 0);
      tbl[10] = mk(0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC,  32'h0,  32'h0,        0, 0, 0, 1);
      tbl[11] = mk(0, 0, 0, 32'h0,        32'h0,         w(63),  32'h0,        1, 1, 0, 1);
      tbl[12] = mk(0, 1, 0, 32'h40,       32'h0,         w(63),  32'h0,        1, 1, 1, 1);

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].r, tbl[i].f, tbl[i].b, tbl[i].a);
         chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("vec%0d inst_out", i), inst_out, tbl[i].e_inst);
         chk($sformatf("vec%0d pc_out", i), pc_out, tbl[i].e_pc);
         chk($sformatf("vec%0d valid_out", i), {31'd0, valid_out}, {31'd0, tbl[i].e_valid});
         chk($sformatf("vec%0d fetch_cnt", i), {16'd0, fetch_cnt}, {16'd0, tbl[i].e_fetch});
         chk($sformatf("vec%0d stall_cnt", i), {16'd0, stall_cnt}, {16'd0, stall_cnt == stall_cnt ? tbl[i].e_stall : 16'hx});
         chk($sformatf("vec%0d flush_cnt", i), {16'd0, flush_cnt}, {16'd0, tbl[i].e_flush});
      end

      // Randomized run against the reference model.
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      model_edge(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      for (int c = 0; c < 1500; c++) begin
         logic r, f, b;
         logic [31:0] a;
         r = ($urandom_range(0, 99) == 0);
         f = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 7) == 0);
         a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 255));
         model_edge(r, f, b, a);
         step(r, f, b, a);
         chk("rnd imem_addr", imem_addr, m_pc);
         chk("rnd inst_out", inst_out, m_inst);
         chk("rnd pc_out", pc_out, m_pco);
         chk("rnd valid_out", {31'd0, valid_out}, {31'd0, m_valid});
         chk("rnd fetch_cnt", {16'd0, fetch_cnt}, {16'd0, m_fetch});
         chk("rnd stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
         chk("rnd flush_cnt", {16'd0, flush_cnt}, {16'd0, m_flush});
      end

      // Narrow counter: free run past 15 fetches, must stick at 15.
      rst4 = 1'b1;
      step(1'b0, 1'b0, 1'b0, 32'd0);
      chk("sat reset fetch_cnt", {28'd0, fetch_cnt4}, 32'd0);
      rst4 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         step(1'b0, 1'b0, 1'b0, 32'd0);
         chk($sformatf("sat cycle%0d fetch_cnt", c), {28'd0, fetch_cnt4},
             (c > 15) ? 32'd15 : 32'(c));
      end
      chk("sat imem_addr", imem_addr4, 32'd80);
      chk("sat stall_cnt", {28'd0, stall_cnt4}, 32'd0);
      chk("sat flush_cnt", {28'd0, flush_cnt4}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
